// File: rtl/qbus_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qbus_reg_slave                                               |
// | Description : Qbus slave cycle engine for the QSIC programmable registers. |
// |               Latches the I/O-page address at SYNC, hands it to the        |
// |               register decoders, and runs the DATI/DATO/DATIO handshake    |
// |               (BDAL drive, RPLY) plus read/write strobes to the devices.   |
// | Options     : QSIC_REG_TIMEOUT_EN - abort any bus cycle that stays in one  |
// |               non-IDLE state for TIMEOUT clocks.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qbus_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DIN_SETTLE  = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rsync,
  input  logic        rbs7,
  input  logic        rdin,
  input  logic        rdout,
  input  logic        rwtbt,
  input  logic [21:0] rdal,
  output logic [15:0] tdal,
  output logic        tdal_oe,
  output logic        trply,
  output logic [12:0] reg_addr,
  output logic        reg_addr_valid,
  input  logic        reg_addr_match,
  input  logic [15:0] reg_rdata,
  output logic        reg_read,
  output logic        reg_write,
  output logic [15:0] reg_wdata,
  output logic [1:0]  reg_byte_en,
  output logic        busy
);

  // Phase counter: wide enough for the abort limit when the timeout is built
  // in, otherwise only wide enough to time the read settle delay.
`ifdef QSIC_REG_TIMEOUT_EN
  localparam int CNT_W = 16;
`else
  localparam int CNT_W = $clog2(DIN_SETTLE + 1) + 1;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    IGNORE = 3'd2,
    SLAVE  = 3'd3,
    RD     = 3'd4,
    WR     = 3'd5
  } state_t;

  // Reject configurations the synchronizer and handshake cannot support.
  if (SYNC_STAGES < 2 || DIN_SETTLE < 1 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_params
    $error("qbus_reg_slave: illegal parameter combination");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;

  logic [SYNC_STAGES-1:0] sync_sh;
  logic [SYNC_STAGES-1:0] din_sh;
  logic [SYNC_STAGES-1:0] dout_sh;
  logic                   sync_prev;
  logic                   din_prev;
  logic                   dout_prev;

  logic sync_s, din_s, dout_s;
  logic sync_rise, sync_fall;
  logic din_rise, din_fall;
  logic dout_rise, dout_fall;
  logic enter_rd, enter_wr;

  logic [15:0] tdal_q;

  // Upper BDAL bits carry only the 22-bit address extension; the engine
  // decodes the I/O page from BBS7 instead.
  logic unused_rdal;
  assign unused_rdal = ^rdal[21:16];

  // Synchronize the asynchronous bus strobes and keep one prior sample for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_sh   <= '0;
      din_sh    <= '0;
      dout_sh   <= '0;
      sync_prev <= 1'b0;
      din_prev  <= 1'b0;
      dout_prev <= 1'b0;
    end else begin
      sync_sh   <= {sync_sh[SYNC_STAGES-2:0], rsync};
      din_sh    <= {din_sh[SYNC_STAGES-2:0], rdin};
      dout_sh   <= {dout_sh[SYNC_STAGES-2:0], rdout};
      sync_prev <= sync_sh[SYNC_STAGES-1];
      din_prev  <= din_sh[SYNC_STAGES-1];
      dout_prev <= dout_sh[SYNC_STAGES-1];
    end
  end

  assign sync_s    = sync_sh[SYNC_STAGES-1];
  assign din_s     = din_sh[SYNC_STAGES-1];
  assign dout_s    = dout_sh[SYNC_STAGES-1];
  assign sync_rise = sync_s & ~sync_prev;
  assign sync_fall = ~sync_s & sync_prev;
  assign din_rise  = din_s & ~din_prev;
  assign din_fall  = ~din_s & din_prev;
  assign dout_rise = dout_s & ~dout_prev;
  assign dout_fall = ~dout_s & dout_prev;

  // State register and per-state cycle counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state logic for the bus cycle; SYNC fall always ends the cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sync_rise) begin
          state_nxt = rbs7 ? DECODE : IGNORE;
        end
      end
      DECODE: begin
        if (sync_fall) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = reg_addr_match ? SLAVE : IGNORE;
        end
      end
      IGNORE: begin
        if (sync_fall) begin
          state_nxt = IDLE;
        end
      end
      SLAVE: begin
        // A simultaneous DIN and DOUT is a protocol error; the read wins.
        if (sync_fall) begin
          state_nxt = IDLE;
        end else if (din_rise) begin
          state_nxt = RD;
        end else if (dout_rise) begin
          state_nxt = WR;
        end
      end
      RD: begin
        if (sync_fall) begin
          state_nxt = IDLE;
        end else if (din_fall) begin
          state_nxt = SLAVE;
        end
      end
      WR: begin
        if (sync_fall) begin
          state_nxt = IDLE;
        end else if (dout_fall) begin
          state_nxt = SLAVE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef QSIC_REG_TIMEOUT_EN
    // A stuck master cannot hold the engine: abort after TIMEOUT clocks in one state.
    if (state != IDLE && cnt >= CNT_W'(TIMEOUT - 1)) begin
      state_nxt = IDLE;
    end
`endif
  end

  assign enter_rd = (state == SLAVE) && (state_nxt == RD);
  assign enter_wr = (state == SLAVE) && (state_nxt == WR);

  // Capture address at SYNC and read/write data on entry to each data phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_addr    <= '0;
      tdal_q      <= '0;
      reg_wdata   <= '0;
      reg_byte_en <= '0;
    end else begin
      if (state == IDLE && sync_rise && rbs7) begin
        reg_addr <= rdal[12:0];
      end
      if (enter_rd) begin
        tdal_q <= reg_rdata;
      end
      if (enter_wr) begin
        reg_wdata   <= rdal[15:0];
        reg_byte_en <= rwtbt ? (reg_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
    end
  end

  // Bus drive and strobes are pure decodes of the state register, so reset
  // or an abort releases the bus on the very next clock.
  always_comb begin
    tdal           = tdal_q;
    tdal_oe        = (state == RD);
    trply          = ((state == RD) && (cnt >= CNT_W'(DIN_SETTLE))) ||
                     ((state == WR) && (cnt >= CNT_W'(1)));
    reg_read       = (state == RD) && (cnt == '0);
    reg_write      = (state == WR) && (cnt == '0);
    reg_addr_valid = (state == DECODE) || (state == SLAVE) ||
                     (state == RD) || (state == WR);
    busy           = (state != IDLE);
  end

endmodule
`default_nettype wire
